// File: rtl/udp_gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : udp_gpio_pkg
//  Description : Shared types and constants for the UDP payload GPIO bank:
//                parser state encoding, header field positions, mode codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package udp_gpio_pkg;

    // Parser states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Header byte layout: bit 7 selects the mode, bits 6..0 the channel
    localparam int MODE_BIT = 7;
    localparam int CH_MSB   = 6;

    localparam logic c_mode_write  = 1'b0;
    localparam logic c_mode_toggle = 1'b1;

    // Number of payload bytes needed to carry one channel value
    function automatic int bytes_for(input int width);
        return (width + 7) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count increment requests, holding at the maximum value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/udp_payload_gpio_bank.sv
`default_nettype none
// ============================================================================
//  Module      : udp_payload_gpio_bank
//  Description : Parses command frames from the UDP payload byte stream and
//                writes or XOR-toggles NUM_CH output channel registers.
//                Frame = header byte (mode, channel) + ceil(CH_WIDTH/8) data
//                bytes, MSB first. Keeps committed/rejected frame counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_payload_gpio_bank
    import udp_gpio_pkg::*;
#(
    parameter int                  NUM_CH      = 4,
    parameter int                  CH_WIDTH    = 8,
    parameter logic [CH_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                  CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tuser,
    output logic [NUM_CH*CH_WIDTH-1:0]   gpio_o,
    output logic                         commit_o,
    output logic [6:0]                   commit_ch_o,
    output logic [CNT_WIDTH-1:0]         frame_cnt_o,
    output logic [CNT_WIDTH-1:0]         err_cnt_o
);

    localparam int c_bytes   = bytes_for(CH_WIDTH);
    localparam int c_stage_w = c_bytes * 8;

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        r_tready;
    logic                        r_mode;
    logic [6:0]                  r_ch;
    logic [2:0]                  r_cnt;
    logic [c_stage_w-1:0]        r_stage;
    logic [NUM_CH*CH_WIDTH-1:0]  r_gpio;
    logic                        r_commit;
    logic [6:0]                  r_commit_ch;

    logic                        w_beat;
    logic                        w_hdr_bad;
    logic                        w_hdr_take;
    logic                        w_commit;
    logic                        w_last_byte;
    logic [2:0]                  w_cnt_inc;
    logic [c_stage_w-1:0]        w_stage_shift;
    logic                        w_unused_bits;

    assign w_beat      = s_axis_tvalid & r_tready;
    assign w_hdr_bad   = ({25'd0, s_axis_tdata[CH_MSB:0]} >= NUM_CH);
    assign w_cnt_inc   = r_cnt + 3'd1;
    assign w_last_byte = (w_cnt_inc == 3'(c_bytes));

    // Staging shift: new byte enters at the bottom, older bytes move up
    if (c_stage_w > 8) begin : g_stage_multi
        assign w_stage_shift = {r_stage[c_stage_w-9:0], s_axis_tdata};
    end else begin : g_stage_single
        assign w_stage_shift = s_axis_tdata;
    end

    // Bits that exist only for some parameterisations (upper staging bits)
    assign w_unused_bits = ^{r_stage, w_stage_shift};

    // Ready is low in reset and high from the first cycle after it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tready <= 1'b0;
        end else begin
            r_tready <= 1'b1;
        end
    end

    // Parser state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and commit decode; ERR also parses a beat as a new header
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        w_hdr_take   = 1'b0;
        case (r_state)
            ST_HDR, ST_ERR: begin
                if (r_state == ST_ERR) begin
                    w_state_next = ST_HDR;
                end
                if (w_beat) begin
                    w_hdr_take = 1'b1;
                    if (w_hdr_bad) begin
                        w_state_next = s_axis_tlast ? ST_ERR : ST_DROP;
                    end else if (s_axis_tlast) begin
                        w_state_next = ST_ERR;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_beat) begin
                    if (w_last_byte) begin
                        if (!s_axis_tlast) begin
                            w_state_next = ST_DROP;
                        end else if (s_axis_tuser) begin
                            w_state_next = ST_ERR;
                        end else begin
                            w_commit     = 1'b1;
                            w_state_next = ST_HDR;
                        end
                    end else if (s_axis_tlast) begin
                        w_state_next = ST_ERR;
                    end
                end
            end
            ST_DROP: begin
                if (w_beat && s_axis_tlast) begin
                    w_state_next = ST_ERR;
                end
            end
            default: w_state_next = ST_HDR;
        endcase
    end

    // Header latch and data byte staging
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode  <= c_mode_write;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_stage <= '0;
        end else if (w_hdr_take) begin
            r_mode  <= s_axis_tdata[MODE_BIT];
            r_ch    <= s_axis_tdata[CH_MSB:0];
            r_cnt   <= '0;
            r_stage <= '0;
        end else if ((r_state == ST_DATA) && w_beat) begin
            r_cnt   <= w_cnt_inc;
            r_stage <= w_stage_shift;
        end
    end

    // Channel update on commit; only the addressed channel changes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_gpio[k*CH_WIDTH +: CH_WIDTH] <= RESET_VALUE;
            end
        end else if (w_commit) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (r_ch == 7'(k)) begin
                    if (r_mode == c_mode_toggle) begin
                        r_gpio[k*CH_WIDTH +: CH_WIDTH] <=
                            r_gpio[k*CH_WIDTH +: CH_WIDTH] ^ w_stage_shift[CH_WIDTH-1:0];
                    end else begin
                        r_gpio[k*CH_WIDTH +: CH_WIDTH] <= w_stage_shift[CH_WIDTH-1:0];
                    end
                end
            end
        end
    end

    // Commit strobe and last-committed channel index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_commit    <= 1'b0;
            r_commit_ch <= '0;
        end else begin
            r_commit <= w_commit;
            if (w_commit) begin
                r_commit_ch <= r_ch;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_frame_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_commit),
        .o_count (frame_cnt_o)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (r_state == ST_ERR),
        .o_count (err_cnt_o)
    );

    assign s_axis_tready = r_tready;
    assign gpio_o        = r_gpio;
    assign commit_o      = r_commit;
    assign commit_ch_o   = r_commit_ch;

endmodule
`default_nettype wire

// File: tb/tb_udp_payload_gpio_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_udp_payload_gpio_bank
//  Description : Self-checking bench for udp_payload_gpio_bank with
//                NUM_CH=4, CH_WIDTH=12. A frame-level model judges each
//                complete datagram and is compared against the DUT every
//                cycle; literal checks pin the expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_payload_gpio_bank;

    localparam int NUM_CH    = 4;
    localparam int CH_WIDTH  = 12;
    localparam int CNT_WIDTH = 16;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [7:0]                  s_axis_tdata = 8'h00;
    logic                        s_axis_tvalid = 1'b0;
    logic                        s_axis_tlast = 1'b0;
    logic                        s_axis_tuser = 1'b0;
    logic                        s_axis_tready;
    logic [NUM_CH*CH_WIDTH-1:0]  gpio_o;
    logic                        commit_o;
    logic [6:0]                  commit_ch_o;
    logic [CNT_WIDTH-1:0]        frame_cnt_o;
    logic [CNT_WIDTH-1:0]        err_cnt_o;

    int n_pass  = 0;
    int n_total = 0;

    udp_payload_gpio_bank #(
        .NUM_CH      (NUM_CH),
        .CH_WIDTH    (CH_WIDTH),
        .RESET_VALUE (12'h000),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .gpio_o        (gpio_o),
        .commit_o      (commit_o),
        .commit_ch_o   (commit_ch_o),
        .frame_cnt_o   (frame_cnt_o),
        .err_cnt_o     (err_cnt_o)
    );

    always #4 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CH_WIDTH-1:0] dut_ch(input int k);
        return gpio_o[k*CH_WIDTH +: CH_WIDTH];
    endfunction

    // ------------------------------------------------------------------
    // Frame-level model: gathers accepted bytes until tlast, then judges
    // the whole datagram. Commits are visible right after the final beat's
    // edge; rejections bump the error count one edge later.
    // ------------------------------------------------------------------
    logic [CH_WIDTH-1:0]  m_gpio [NUM_CH];
    logic                 m_commit = 1'b0;
    logic [6:0]           m_commit_ch = '0;
    logic [CNT_WIDTH-1:0] m_frames = '0;
    logic [CNT_WIDTH-1:0] m_errs = '0;
    logic                 m_tready = 1'b0;
    bit                   m_err_pending = 1'b0;
    bit                   m_started = 1'b0;
    logic [7:0]           m_buf [$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_started     = 1'b1;
            m_tready      = 1'b0;
            m_commit      = 1'b0;
            m_commit_ch   = '0;
            m_frames      = '0;
            m_errs        = '0;
            m_err_pending = 1'b0;
            m_buf.delete();
            for (int k = 0; k < NUM_CH; k++) m_gpio[k] = '0;
        end else begin
            m_commit = 1'b0;
            if (m_err_pending) begin
                if (m_errs != '1) m_errs = m_errs + 1'b1;
                m_err_pending = 1'b0;
            end
            if (s_axis_tvalid && m_tready) begin
                m_buf.push_back(s_axis_tdata);
                if (s_axis_tlast) begin
                    int ch;
                    logic [15:0] val;
                    ch = int'(m_buf[0] & 8'h7F);
                    if (ch < NUM_CH && m_buf.size() == 3 && !s_axis_tuser) begin
                        val = {m_buf[1], m_buf[2]};
                        if (m_buf[0][7]) m_gpio[ch] = m_gpio[ch] ^ val[CH_WIDTH-1:0];
                        else             m_gpio[ch] = val[CH_WIDTH-1:0];
                        m_commit    = 1'b1;
                        m_commit_ch = 7'(ch);
                        if (m_frames != '1) m_frames = m_frames + 1'b1;
                    end else begin
                        m_err_pending = 1'b1;
                    end
                    m_buf.delete();
                end
            end
            m_tready = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_started) begin
            for (int k = 0; k < NUM_CH; k++) check($sformatf("cyc_ch%0d", k), 64'(dut_ch(k)), 64'(m_gpio[k]));
            check("cyc_commit",    64'(commit_o),      64'(m_commit));
            check("cyc_commit_ch", 64'(commit_ch_o),   64'(m_commit_ch));
            check("cyc_frame_cnt", 64'(frame_cnt_o),   64'(m_frames));
            check("cyc_err_cnt",   64'(err_cnt_o),     64'(m_errs));
            check("cyc_tready",    64'(s_axis_tready), 64'(m_tready));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge+1)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic user, input bit gaps);
        int n;
        if (gaps) idle($urandom_range(0, 3));
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        n = 0;
        while (!s_axis_tready && n < 100) begin
            idle(1);
            n++;
        end
        if (n >= 100) check("tready_timeout", 64'(s_axis_tready), 64'd1);
        idle(1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input int len, input logic user, input bit gaps);
        logic [7:0] b [4];
        b = '{b0, b1, b2, b3};
        for (int i = 0; i < len; i++) begin
            send_beat(b[i], (i == len - 1), (i == len - 1) ? user : 1'b0, gaps);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        idle(3);
        check("rst_tready",    64'(s_axis_tready), 64'd0);
        check("rst_gpio",      64'(gpio_o),        64'd0);
        check("rst_commit",    64'(commit_o),      64'd0);
        check("rst_commit_ch", 64'(commit_ch_o),   64'd0);
        check("rst_frames",    64'(frame_cnt_o),   64'd0);
        check("rst_errs",      64'(err_cnt_o),     64'd0);
        rst_n = 1'b1;
        idle(1);
        check("tready_after_rst", 64'(s_axis_tready), 64'd1);

        // Write 0xABC to channel 2
        send_frame(8'h02, 8'h0A, 8'hBC, 8'h00, 3, 1'b0, 1'b0);
        check("wr_commit_pulse", 64'(commit_o),    64'd1);
        check("wr_commit_ch",    64'(commit_ch_o), 64'd2);
        idle(2);
        check("wr_ch2",     64'(dut_ch(2)),   64'h0ABC);
        check("wr_others",  64'({dut_ch(3), dut_ch(1), dut_ch(0)}), 64'd0);
        check("wr_frames",  64'(frame_cnt_o), 64'd1);
        check("wr_pulse_1c", 64'(commit_o),   64'd0);

        // Toggle channel 2 with 0x00F
        send_frame(8'h82, 8'h00, 8'h0F, 8'h00, 3, 1'b0, 1'b0);
        idle(2);
        check("tg_ch2",    64'(dut_ch(2)),   64'h0AB3);
        check("tg_frames", 64'(frame_cnt_o), 64'd2);

        // Bad channel, then header-only frame
        send_frame(8'h05, 8'h11, 8'h22, 8'h00, 3, 1'b0, 1'b0);
        idle(3);
        check("badch_errs", 64'(err_cnt_o), 64'd1);
        send_frame(8'h01, 8'h00, 8'h00, 8'h00, 1, 1'b0, 1'b0);
        idle(3);
        check("hdronly_errs", 64'(err_cnt_o), 64'd2);

        // Short, long, then a good frame back-to-back
        send_frame(8'h01, 8'h12, 8'h00, 8'h00, 2, 1'b0, 1'b0);
        idle(3);
        check("short_errs", 64'(err_cnt_o), 64'd3);
        check("short_ch1",  64'(dut_ch(1)), 64'd0);
        send_frame(8'h01, 8'h12, 8'h34, 8'h56, 4, 1'b0, 1'b0);
        send_frame(8'h01, 8'h0F, 8'hFF, 8'h00, 3, 1'b0, 1'b0);
        idle(3);
        check("long_errs",  64'(err_cnt_o),   64'd4);
        check("b2b_ch1",    64'(dut_ch(1)),   64'h0FFF);
        check("b2b_frames", 64'(frame_cnt_o), 64'd3);

        // Frame error flag on the final beat
        send_frame(8'h03, 8'h01, 8'h23, 8'h00, 3, 1'b1, 1'b0);
        idle(3);
        check("tuser_ch3",  64'(dut_ch(3)), 64'd0);
        check("tuser_errs", 64'(err_cnt_o), 64'd5);

        // Same kinds of frames with random valid gaps
        send_frame(8'h00, 8'h01, 8'h23, 8'h00, 3, 1'b0, 1'b1);
        send_frame(8'h03, 8'h01, 8'h23, 8'h00, 3, 1'b1, 1'b1);
        send_frame(8'h82, 8'h00, 8'h0F, 8'h00, 3, 1'b0, 1'b1);
        send_frame(8'h01, 8'h12, 8'h00, 8'h00, 2, 1'b0, 1'b1);
        idle(3);
        check("gap_ch0",    64'(dut_ch(0)),   64'h0123);
        check("gap_ch2",    64'(dut_ch(2)),   64'h0ABC);
        check("gap_ch3",    64'(dut_ch(3)),   64'd0);
        check("gap_frames", 64'(frame_cnt_o), 64'd5);
        check("gap_errs",   64'(err_cnt_o),   64'd7);

        // Reset in the middle of a frame
        send_beat(8'h00, 1'b0, 1'b0, 1'b0);
        send_beat(8'h05, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        idle(1);
        check("mid_rst_tready", 64'(s_axis_tready), 64'd0);
        check("mid_rst_gpio",   64'(gpio_o),        64'd0);
        check("mid_rst_frames", 64'(frame_cnt_o),   64'd0);
        check("mid_rst_errs",   64'(err_cnt_o),     64'd0);
        rst_n = 1'b1;
        send_frame(8'h00, 8'h05, 8'h55, 8'h00, 3, 1'b0, 1'b0);
        idle(3);
        check("post_rst_ch0",    64'(dut_ch(0)),   64'h0555);
        check("post_rst_frames", 64'(frame_cnt_o), 64'd1);
        check("post_rst_errs",   64'(err_cnt_o),   64'd0);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard bound on total run time
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
